// File: rtl/accel_spi_if.sv
// Command/status and SPI pin bundle for accel_spi_master.
// The irq/irq_ack pair exists only when ACCEL_SPI_IRQ_EN is defined.
interface accel_spi_if;
    logic        start;
    logic        rw;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic [1:0]  nbytes_m1;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        cs_n;
`ifdef ACCEL_SPI_IRQ_EN
    logic        irq;
    logic        irq_ack;

    modport master (
        input  start, rw, addr, wdata, nbytes_m1, miso, irq_ack,
        output busy, done, rdata, sclk, mosi, cs_n, irq
    );
    modport slave (
        output start, rw, addr, wdata, nbytes_m1, miso, irq_ack,
        input  busy, done, rdata, sclk, mosi, cs_n, irq
    );
`else
    modport master (
        input  start, rw, addr, wdata, nbytes_m1, miso,
        output busy, done, rdata, sclk, mosi, cs_n
    );
    modport slave (
        output start, rw, addr, wdata, nbytes_m1, miso,
        input  busy, done, rdata, sclk, mosi, cs_n
    );
`endif
endinterface

// File: rtl/accel_spi_master.sv
// SPI mode-0 master for accelerometer register read bursts (0x0B) and writes (0x0A).
// Optional sticky completion interrupt: define ACCEL_SPI_IRQ_EN.
module accel_spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    accel_spi_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] CMD_RD   = 8'h0B;
    localparam logic [7:0] CMD_WR   = 8'h0A;

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  div_cnt_r;
    logic [5:0]  edge_cnt_r;
    logic [5:0]  edge_total_r;
    logic        rd_r;
    logic [23:0] sh_r;
    logic        sclk_r;
    logic        mosi_r;
    logic        cs_n_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] rdata_r;

    logic        cnt_last_s;
    logic        accept_s;
    logic        rise_s;
    logic        fall_s;
    logic        finish_s;
    logic        gap_end_s;
    logic        capture_s;
    logic [5:0]  edge_next_s;
    logic [4:0]  bit_idx_s;

    assign cnt_last_s  = (div_cnt_r == DIV_LAST);
    assign edge_next_s = edge_cnt_r + 6'd1;
    // Read data bit j arrives on rising edge 18+j; j maps to byte j/8, MSB first.
    assign bit_idx_s   = 5'(edge_next_s - 6'd18);
    assign capture_s   = rd_r && (edge_next_s >= 6'd18) && (edge_next_s <= edge_total_r);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and per-cycle datapath strobes
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        rise_s    = 1'b0;
        fall_s    = 1'b0;
        finish_s  = 1'b0;
        gap_end_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    accept_s = 1'b1;
                    state_s  = ST_SETUP;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_last_s) begin
                    rise_s  = 1'b1;
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_SHIFT: begin
                if (!cnt_last_s) begin
                    state_s = ST_SHIFT;
                end else if (sclk_r) begin
                    fall_s  = 1'b1;
                end else if (edge_cnt_r == edge_total_r) begin
                    state_s = ST_HOLD;
                end else begin
                    rise_s  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_last_s) begin
                    finish_s = 1'b1;
                    state_s  = ST_GAP;
                end else begin
                    state_s  = ST_HOLD;
                end
            end
            ST_GAP: begin
                if (cnt_last_s) begin
                    gap_end_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s   = ST_GAP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: dividers, shift word, SPI pins, read capture and status
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_r    <= 8'd0;
            edge_cnt_r   <= 6'd0;
            edge_total_r <= 6'd0;
            rd_r         <= 1'b0;
            sh_r         <= 24'd0;
            sclk_r       <= 1'b0;
            mosi_r       <= 1'b0;
            cs_n_r       <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            rdata_r      <= 32'd0;
        end else begin
            done_r <= finish_s;

            if (accept_s) begin
                div_cnt_r  <= 8'd0;
                edge_cnt_r <= 6'd0;
                rd_r       <= bus.rw;
                rdata_r    <= 32'd0;
                cs_n_r     <= 1'b0;
                busy_r     <= 1'b1;
                // Reads carry no data byte; the slot after the address shifts zeros.
                if (bus.rw) begin
                    sh_r         <= {CMD_RD, bus.addr, 8'h00};
                    mosi_r       <= CMD_RD[7];
                    edge_total_r <= 6'd25 + {1'b0, bus.nbytes_m1, 3'b000};
                end else begin
                    sh_r         <= {CMD_WR, bus.addr, bus.wdata};
                    mosi_r       <= CMD_WR[7];
                    edge_total_r <= 6'd24;
                end
            end else if (state_r != ST_IDLE) begin
                div_cnt_r <= cnt_last_s ? 8'd0 : div_cnt_r + 8'd1;
            end

            if (rise_s) begin
                sclk_r     <= 1'b1;
                edge_cnt_r <= edge_next_s;
                if (capture_s) begin
                    rdata_r[bit_idx_s ^ 5'b00111] <= bus.miso;
                end
            end

            if (fall_s) begin
                sclk_r <= 1'b0;
                mosi_r <= sh_r[22];
                sh_r   <= {sh_r[22:0], 1'b0};
            end

            if (finish_s) begin
                cs_n_r <= 1'b1;
            end

            if (gap_end_s) begin
                busy_r <= 1'b0;
            end
        end
    end

    assign bus.sclk  = sclk_r;
    assign bus.mosi  = mosi_r;
    assign bus.cs_n  = cs_n_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.rdata = rdata_r;

`ifdef ACCEL_SPI_IRQ_EN
    logic irq_r;

    // Sticky interrupt; a new completion beats a simultaneous acknowledge
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_r <= 1'b0;
        end else if (finish_s) begin
            irq_r <= 1'b1;
        end else if (bus.irq_ack && !done_r) begin
            irq_r <= 1'b0;
        end
    end

    assign bus.irq = irq_r;
`endif

endmodule

// File: tb/tb_accel_spi_master.sv
// Directed bench for accel_spi_master against a register-file SPI slave model
// whose registers 0..19 hold their own index.
module tb_accel_spi_master;

`ifdef ACCEL_SPI_IRQ_EN
    localparam int DIV = 1;
`else
    localparam int DIV = 4;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    accel_spi_if bus ();

    accel_spi_master #(.CLK_DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [1:0]  nbm1;
        logic [31:0] exp_rdata;
        int          exp_edges;
        logic [23:0] exp_hdr;
    } vec_t;

    vec_t vecs [5];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc;

    // Slave model state (written only by the model process)
    int          sl_edges    = 0;
    int          sl_bad      = 0;
    int          sl_cs_rises = 0;
    int          sl_j;
    logic [7:0]  sl_b;
    logic [63:0] sl_mosi     = '0;
    logic [15:0] sl_hdr16    = '0;
    logic [23:0] sl_hdr24    = '0;
    logic        sl_sclk_prev = 1'b0;
    logic        sl_cs_prev   = 1'b1;

    function automatic logic [7:0] reg_val(input logic [7:0] a);
        return (a < 8'd20) ? a : 8'h00;
    endfunction

    // Mode-0 slave: samples MOSI on SCLK rise, drives MISO after each fall
    always @(posedge clk) begin
        #1;
        if (!bus.cs_n && sl_cs_prev) begin
            sl_edges = 0;
            sl_mosi  = '0;
            sl_hdr16 = '0;
            sl_hdr24 = '0;
        end
        if (bus.cs_n) bus.miso = 1'b0;
        if (bus.sclk && !sl_sclk_prev) begin
            if (bus.cs_n) begin
                sl_bad++;
            end else begin
                sl_edges++;
                sl_mosi = {sl_mosi[62:0], bus.mosi};
                if (sl_edges == 16) sl_hdr16 = sl_mosi[15:0];
                if (sl_edges == 24) sl_hdr24 = sl_mosi[23:0];
            end
        end else if (!bus.sclk && sl_sclk_prev && !bus.cs_n && sl_edges >= 17) begin
            sl_j     = sl_edges - 17;
            sl_b     = reg_val(sl_hdr16[7:0] + 8'(sl_j / 8));
            bus.miso = sl_b[7 - (sl_j % 8)];
        end
        if (bus.cs_n && !sl_cs_prev) sl_cs_rises++;
        sl_sclk_prev = bus.sclk;
        sl_cs_prev   = bus.cs_n;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Caller must be 1 ns after a rising edge; start is presented immediately.
    task automatic run_txn(input logic rw, input logic [7:0] addr, input logic [7:0] wdata,
                           input logic [1:0] nbm1, input bit poke_mid, input bit poke_done,
                           input bit ack_done, output int done_cyc, output int gap);
        int cs0;
        int extra;
        cs0      = sl_cs_rises;
        done_cyc = -1;
        gap      = -1;
        extra    = 0;
        bus.rw        = rw;
        bus.addr      = addr;
        bus.wdata     = wdata;
        bus.nbytes_m1 = nbm1;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        check("accept_busy", {31'd0, bus.busy}, 32'd1);
        check("accept_cs_n", {31'd0, bus.cs_n}, 32'd0);
        while (bus.busy && cyc < 6000) begin
            @(posedge clk); #1;
            cyc++;
            bus.start = 1'b0;
`ifdef ACCEL_SPI_IRQ_EN
            bus.irq_ack = ack_done && bus.done;
`endif
            if (poke_mid && cyc == 20) begin
                bus.start = 1'b1;
                bus.rw    = ~rw;
                bus.addr  = 8'hFF;
            end
            if (bus.done) begin
                if (done_cyc < 0) done_cyc = cyc;
                else extra++;
                if (poke_done) bus.start = 1'b1;
`ifdef ACCEL_SPI_IRQ_EN
                check("irq_with_done", {31'd0, bus.irq}, 32'd1);
`endif
            end
        end
        if (done_cyc >= 0) gap = cyc - done_cyc;
        check("busy_timeout", {31'd0, bus.busy}, 32'd0);
        check("done_single", extra, 32'd0);
        check("cs_n_rises", sl_cs_rises - cs0, 32'd1);
    endtask

    initial begin
        int dc;
        int gp;
        int done_seen;

        vecs[0] = '{1'b1, 8'h0E, 8'h00, 2'd1, 32'h00000F0E, 33, 24'h0B0E00};
        vecs[1] = '{1'b1, 8'h08, 8'h00, 2'd3, 32'h0B0A0908, 49, 24'h0B0800};
        vecs[2] = '{1'b0, 8'h2D, 8'h02, 2'd3, 32'h00000000, 24, 24'h0A2D02};
        vecs[3] = '{1'b1, 8'h03, 8'h00, 2'd0, 32'h00000003, 25, 24'h0B0300};
        vecs[4] = '{1'b1, 8'h10, 8'h00, 2'd2, 32'h00121110, 41, 24'h0B1000};

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.rw        = 1'b0;
        bus.addr      = 8'h00;
        bus.wdata     = 8'h00;
        bus.nbytes_m1 = 2'd0;
`ifdef ACCEL_SPI_IRQ_EN
        bus.irq_ack   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_cs_n",  {31'd0, bus.cs_n}, 32'd1);
        check("rst_sclk",  {31'd0, bus.sclk}, 32'd0);
        check("rst_mosi",  {31'd0, bus.mosi}, 32'd0);
        check("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check("rst_done",  {31'd0, bus.done}, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
`ifdef ACCEL_SPI_IRQ_EN
        check("rst_irq",   {31'd0, bus.irq}, 32'd0);
`endif

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].nbm1, 1'b0, 1'b0, 1'b0, dc, gp);
            check($sformatf("v%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_edges", i), sl_edges, vecs[i].exp_edges);
            check($sformatf("v%0d_hdr16", i), {16'd0, sl_hdr16}, {16'd0, vecs[i].exp_hdr[23:8]});
            if (!vecs[i].rw) check($sformatf("v%0d_hdr24", i), {8'd0, sl_hdr24}, {8'd0, vecs[i].exp_hdr});
            check($sformatf("v%0d_done_cyc", i), dc, 1 + 2 * DIV + 2 * DIV * vecs[i].exp_edges);
            check($sformatf("v%0d_gap", i), gp, DIV);
        end

        // start mid-SHIFT and on the done cycle are dropped; the next start
        // lands on the first idle cycle
        run_txn(1'b1, 8'h03, 8'h00, 2'd0, 1'b1, 1'b1, 1'b0, dc, gp);
        check("ign_rdata", bus.rdata, 32'h00000003);
        check("ign_edges", sl_edges, 32'd25);
        check("ign_done_cyc", dc, 1 + 2 * DIV + 2 * DIV * 25);
        check("ign_gap", gp, DIV);
        run_txn(1'b1, 8'h05, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, dc, gp);
        check("b2b_rdata", bus.rdata, 32'h00000005);
        check("b2b_done_cyc", dc, 1 + 2 * DIV + 2 * DIV * 25);

        // Reset while SCLK is high for rising edge 10, with a competing start
        bus.rw        = 1'b1;
        bus.addr      = 8'h0E;
        bus.nbytes_m1 = 2'd1;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < 1 + 19 * DIV) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("edge10_sclk", {31'd0, bus.sclk}, 32'd1);
        reset     = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        check("mrst_cs_n",  {31'd0, bus.cs_n}, 32'd1);
        check("mrst_sclk",  {31'd0, bus.sclk}, 32'd0);
        check("mrst_busy",  {31'd0, bus.busy}, 32'd0);
        check("mrst_done",  {31'd0, bus.done}, 32'd0);
        check("mrst_rdata", bus.rdata, 32'd0);
        done_seen = 0;
        for (int k = 0; k < 4 * DIV + 4; k++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) done_seen++;
        end
        check("mrst_quiet", done_seen, 32'd0);
        run_txn(1'b1, 8'h03, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, dc, gp);
        check("post_rst_rdata", bus.rdata, 32'h00000003);

`ifdef ACCEL_SPI_IRQ_EN
        repeat (5) @(posedge clk);
        #1;
        check("irq_sticky", {31'd0, bus.irq}, 32'd1);
        bus.irq_ack = 1'b1;
        @(posedge clk); #1;
        bus.irq_ack = 1'b0;
        check("irq_cleared", {31'd0, bus.irq}, 32'd0);
        run_txn(1'b1, 8'h04, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, dc, gp);
        bus.irq_ack = 1'b0;
        check("irq_set_wins", {31'd0, bus.irq}, 32'd1);
        check("irq_rdata", bus.rdata, 32'h00000004);
`endif

        check("sclk_while_cs_high", sl_bad, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accel_spi_master.md
# accel_spi_master

SPI mode-0 master that runs register transactions against the three-axis accelerometer for the PicoRV32 system. It sits between the memory-mapped accelerometer peripheral registers (upstream: firmware issues a command) and the board SPI pins (downstream: the accelerometer). It serialises the read (0x0B) and write (0x0A) command frames, captures burst read data, and reports completion with a single-cycle `done` pulse.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SCLK half-period; legal 1..255.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a transaction; sampled only while `busy`=0.
- `rw`  in  1  1 = read (command 0x0B), 0 = write (command 0x0A).
- `addr`  in  8  accelerometer register address.
- `wdata`  in  8  write data byte (ignored for reads).
- `nbytes_m1`  in  2  read burst length minus one (0..3 → 1..4 bytes); ignored for writes.
- `busy`  out  1  transaction in progress or CS recovery gap.
- `done`  out  1  one-cycle pulse at transaction end.
- `rdata`  out  32  read result; byte k of the burst in bits [8k+7:8k]; unread bytes 0.
- `sclk`  out  1  SPI clock, idle low.
- `mosi`  out  1  master data out, MSB first.
- `miso`  in  1  slave data in.
- `cs_n`  out  1  chip select, active low.
- `irq`  out  1  sticky completion interrupt (only with `ACCEL_SPI_IRQ_EN`).
- `irq_ack`  in  1  clears `irq` (only with `ACCEL_SPI_IRQ_EN`).

## Operation
- Reset values: `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rdata`=0, `irq`=0.
- States: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE: on `start`=1, latch `rw`, `addr`, `wdata`, `nbytes_m1`; build shift word {cmd, addr, wdata}; clear `rdata`; go to SETUP; `busy`=1 and `cs_n`=0 from the next cycle.
- SETUP: `mosi` = cmd bit 7; wait `CLK_DIV` cycles; go to SHIFT.
- SHIFT: each SCLK period = `CLK_DIV` cycles high, then `CLK_DIV` cycles low. `mosi` updates only on SCLK falling edges (next bit of shift word; 0 after the word is exhausted).
- Write frame: 24 rising edges (cmd, addr, data); `miso` ignored.
- Read frame: 16 rising edges (cmd, addr) + 1 turnaround edge + 8·N data edges, N = `nbytes_m1`+1. The slave drives each bit on the falling edge after its preceding rising edge, so data bit j (j=0 is byte 0 MSB) is captured on rising edge 18+j. Total edges: 25, 33, 41, 49 for N=1..4.
- Edge counter is 6 bits; SHIFT ends after the final low half-period.
- HOLD: `sclk`=0, `cs_n`=0 for `CLK_DIV` cycles; then `cs_n`=1, `done`=1 for one cycle, `rdata` final; go to GAP.
- GAP: `cs_n`=1 for `CLK_DIV` cycles, `busy` still 1; then IDLE with `busy`=0.
- `start` while `busy`=1 is ignored, not queued.
- `rdata` holds its value until the next accepted `start`.

## Timing
- Cycle 0: `start` accepted. Cycle 1: `cs_n` falls, `busy` rises.
- First SCLK rising edge at cycle 1+`CLK_DIV`.
- `done` cycle = 1 + `CLK_DIV` + 2·`CLK_DIV`·E + `CLK_DIV`, where E = edge count (24 for writes, 17+8N for reads).
- `busy` falls `CLK_DIV` cycles after `done`; `start` is accepted on the first cycle `busy`=0.
- `miso` is sampled in the same `clk` cycle that `sclk` is driven high (registered output, so 1 cycle after the pin edge); with `CLK_DIV`≥1 this is inside the slave's stable window.
- `reset` mid-transaction: on the next edge `cs_n`=1, `sclk`=0, `busy`=0; no `done`; `rdata`=0.
- `start` and `reset` in the same cycle: reset wins.

## Configuration
- `ACCEL_SPI_IRQ_EN` defined: `irq` is set on the `done` cycle and stays set until a cycle with `irq_ack`=1. If `done` and `irq_ack` coincide, set wins.
- Not defined: `irq` and `irq_ack` ports are absent; completion is signalled only by `done` and `busy`.

## Test plan
- Model slave whose registers 0..19 hold their own index. Read with `addr`=0x0E, `nbytes_m1`=1, `CLK_DIV`=4 → MOSI bytes 0x0B, 0x0E; 33 SCLK edges; `rdata`=0x00000F0E; `done` at cycle 1+4+264+4=273.
- Same model, read with `addr`=0x08, `nbytes_m1`=3 → 49 edges; `rdata`=0x0B0A0908.
- Write with `addr`=0x2D, `wdata`=0x02 → MOSI bytes 0x0A, 0x2D, 0x02; exactly 24 edges; `cs_n` low throughout; `rdata`=0.
- `start` pulsed in the middle of SHIFT and again on the `done` cycle → both ignored; a `start` on the first cycle `busy`=0 is accepted.
- `reset` asserted at rising edge 10 of a read → next cycle `cs_n`=1, `sclk`=0, `busy`=0, no `done`; a following read of `addr`=0x03 returns 0x00000003.
- With `ACCEL_SPI_IRQ_EN` and `CLK_DIV`=1: `irq` rises with `done`, stays high until `irq_ack`; `irq_ack` coinciding with a second `done` leaves `irq`=1.
